pmp_check_unit: RTL
===================

Name: pmp_check_unit

Overview:
- Physical Memory Protection register file and access checker, 32-bit physical addresses.
- Holds pmpcfg/pmpaddr state, written by the CSR unit.
- Pre-decodes each entry's NAPOT mask and match address into registers after every write.
- Checks load/store/fetch requests from the LSU and fetch paths, with a registered one-cycle response.

Parameters:
- NUM_ENTRIES, 8, number of PMP entries (1..16).

Ports:
- cpu_clock_i  in  1  clock.
- cpu_reset_i  in  1  synchronous active-high reset.
- csr_wr_i  in  1  CSR write strobe.
- csr_addr_i  in  12  CSR address: pmpcfg0..3 = 0x3A0..0x3A3, pmpaddr0..15 = 0x3B0..0x3BF.
- csr_wdata_i  in  32  write data.
- csr_rdata_o  out  32  combinational read of csr_addr_i; 0 for unimplemented entries.
- req_valid_i  in  1  check request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_addr_i  in  32  byte address.
- req_type_i  in  2  00 load, 01 store, 10 fetch; 11 is treated as a load.
- req_priv_m_i  in  1  1 = M-mode, 0 = U-mode.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_fault_o  out  1  access fault.
- rsp_entry_o  out  4  matching entry index; 0xF on no match.

Behaviour:
- Reset: all cfg = 0, all addr = 0, decode registers = 0, state = UPD, rsp_valid_o = 0, rsp_fault_o = 0, rsp_entry_o = 0xF.
- Reset mid-operation discards any pending response.
- cfg byte per entry: [0] R, [1] W, [2] X, [4:3] A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), [7] L. Bits [6:5] read as 0.
- pmpaddr holds pa[33:2]. Only bits [29:0] are stored; [31:30] read as 0.
- Write rules:
  - Entry with L = 1: ignores writes to its cfg byte and its pmpaddr.
  - pmpaddr[i] also ignores writes when entry i+1 has L = 1 and A = TOR.
  - A pmpcfg write updates the four bytes independently under these rules.
- NAPOT decode for t = number of trailing ones in pmpaddr:
  - mask = ~((1 << (t+1)) - 1); match = pmpaddr & mask.
  - Region size is 2^(t+3) bytes.
  - All-ones pmpaddr: mask = 0, whole space matches.
- NA4: mask = all ones, match = pmpaddr.
- TOR: entry i matches when lower <= req_addr[31:2] < pmpaddr[i].
  - lower = pmpaddr[i-1]; lower = 0 for entry 0.
  - lower >= upper matches nothing.
- State machine:
  - RDY: req_ready_o = !csr_wr_i && !(rsp_valid_o && !rsp_ready_i).
  - Any csr_wr_i to a pmp address (accepted or ignored): RDY -> UPD.
  - UPD: lasts exactly one cycle; decode registers are loaded from the new addr/cfg; req_ready_o = 0; then -> RDY.
  - Back-to-back writes keep the block in UPD until one cycle after the last write.
  - A write and a request in the same cycle: write wins, request not accepted.
- Check: request accepted in cycle N → response in N+1 (rsp_valid_o = 1).
  - Response fields are held stable until rsp_ready_i.
  - Accept in the same cycle as rsp_ready_i is allowed (full throughput).
- Match priority: lowest-numbered matching entry with A != OFF.
- Fault rules:
  - Match, U-mode: fault unless the permission for req_type is set (load → R, store → W, fetch → X).
  - Match, M-mode: permissions apply only if L = 1; otherwise allow.
  - No match: M-mode allows; U-mode faults; rsp_entry_o = 0xF.
- Check operates on decoded registers only; all 30 address bits are compared (req_addr[31:2]).

Test Plan:
- Reset → csr_rdata_o(0x3B0) = 0; UPD for one cycle then req_ready_o = 1. U-mode load 0x0000_1000 → fault = 1, entry = 0xF. M-mode same address → fault = 0.
- Write pmpaddr0 = 0x0000_03FF (NAPOT over 0x0000_0000–0x0000_1FFF), pmpcfg0 = 0x1B (NAPOT, R, W). req_ready_o = 0 for the cycle after each write.
  - U load 0x0000_1FFC → no fault, entry 0.
  - U fetch 0x0000_1000 → fault, entry 0.
  - U load 0x0000_2000 → fault, entry 0xF.
- TOR: pmpaddr1 = 0x0000_0800, pmpaddr2 = 0x0000_0C00, pmpcfg0 = 0x000D_0000 (entry 2 TOR, X).
  - U fetch 0x0000_2FFC → ok, entry 2.
  - U fetch 0x0000_3000 → fault, entry 0xF.
  - pmpaddr1 = 0x0C00 → entry 2 matches nothing.
- Lock: pmpcfg0 byte0 = 0x99 (L, NAPOT, R). Write pmpaddr0 = 0 → readback unchanged. M-mode store 0x0000_0010 → fault, entry 0.
- Backpressure: rsp_ready_i = 0 for 3 cycles with req_valid_i held → req_ready_o = 0, response stable. Release → next response one cycle after acceptance.
- Simultaneous csr_wr_i and req_valid_i → request not accepted. Accepted after UPD, and the check uses the newly written values.

Source files
------------

// File: rtl/pmp_check_unit.sv
// Physical Memory Protection register file and access checker (32-bit PA).
//
// Holds the pmpcfg/pmpaddr state written by the CSR unit. After each write,
// every entry's region is pre-decoded into registers. Load, store and fetch
// requests are checked against those registers, and the result is returned
// as a registered response one cycle after the request is accepted.
//
// Ports:
//   cpu_clock_i, cpu_reset_i   clock, synchronous active-high reset
//   csr_wr_i/addr/wdata        CSR write port (pmpcfg0..3, pmpaddr0..15)
//   csr_rdata_o                combinational read of csr_addr_i
//   req_valid_i/ready_o        check request handshake
//   req_addr_i/type_i/priv_m_i byte address, 00 ld 01 st 10 fetch, M-mode flag
//   rsp_valid_o/ready_i        response handshake
//   rsp_fault_o/entry_o        access fault, matching entry (0xF = none)
//
// state | meaning
// RDY   | decode registers current, requests may be accepted
// UPD   | decode registers reloading from addr/cfg, requests blocked
module pmp_check_unit #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        csr_wr_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_type_i,
  input  logic        req_priv_m_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_fault_o,
  output logic [3:0]  rsp_entry_o
);

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  typedef enum logic {ST_RDY, ST_UPD} state_t;

  state_t      state;
  logic [7:0]  cfg      [NUM_ENTRIES];
  logic [29:0] addr     [NUM_ENTRIES];
  // For NAPOT/NA4 dec_lo is the match value and dec_hi the mask;
  // for TOR they are the lower and upper word bounds.
  logic [29:0] dec_lo   [NUM_ENTRIES];
  logic [29:0] dec_hi   [NUM_ENTRIES];
  logic [1:0]  dec_mode [NUM_ENTRIES];
  logic [3:0]  dec_perm [NUM_ENTRIES];   // {L, X, W, R}

  logic [29:0] nxt_lo   [NUM_ENTRIES];
  logic [29:0] nxt_hi   [NUM_ENTRIES];
  logic [29:0] prev_addr[NUM_ENTRIES];

  logic [NUM_ENTRIES:0]   tor_lock;
  logic [NUM_ENTRIES-1:0] addr_lock;
  logic [NUM_ENTRIES-1:0] hit_vec;

  logic        cfg_sel, addr_sel, pmp_wr, accept;
  logic [1:0]  cfg_idx;
  logic [3:0]  addr_idx;
  logic [29:0] req_word;
  logic        hit_found, perm_ok, chk_fault;
  logic [3:0]  hit_idx, hit_perm;
  logic        unused_bits;

  assign cfg_sel  = (csr_addr_i[11:2] == 10'h0E8);   // 0x3A0..0x3A3
  assign addr_sel = (csr_addr_i[11:4] == 8'h3B);     // 0x3B0..0x3BF
  assign cfg_idx  = csr_addr_i[1:0];
  assign addr_idx = csr_addr_i[3:0];
  assign pmp_wr   = csr_wr_i && (cfg_sel || addr_sel);
  assign req_word = req_addr_i[31:2];
  assign unused_bits = ^req_addr_i[1:0];

  assign req_ready_o = (state == ST_RDY) && !csr_wr_i && !(rsp_valid_o && !rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    csr_rdata_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cfg_sel && int'(cfg_idx) == i / 4)
        csr_rdata_o[8*(i%4) +: 8] = cfg[i];
      if (addr_sel && int'(addr_idx) == i)
        csr_rdata_o = {2'b00, addr[i]};
    end
  end

  // pmpaddr[i] is frozen by its own lock, or by a locked TOR entry above it
  // that uses it as the lower bound.
  always_comb begin
    tor_lock = '0;
    addr_lock = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      tor_lock[i] = cfg[i][7] && (cfg[i][4:3] == A_TOR);
    for (int i = 0; i < NUM_ENTRIES; i++)
      addr_lock[i] = cfg[i][7] || tor_lock[i+1];
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) prev_addr[i] = '0;
    for (int i = 1; i < NUM_ENTRIES; i++) prev_addr[i] = addr[i-1];
  end

  // NAPOT: addr ^ (addr + 1) sets bits [t:0] for t trailing ones; an
  // all-ones address wraps to zero and so yields an all-zero mask.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      nxt_lo[i] = '0;
      nxt_hi[i] = '0;
      case (cfg[i][4:3])
        A_TOR: begin
          nxt_lo[i] = prev_addr[i];
          nxt_hi[i] = addr[i];
        end
        A_NA4: begin
          nxt_lo[i] = addr[i];
          nxt_hi[i] = '1;
        end
        A_NAPOT: begin
          nxt_hi[i] = ~(addr[i] ^ (addr[i] + 30'd1));
          nxt_lo[i] = addr[i] & ~(addr[i] ^ (addr[i] + 30'd1));
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      case (dec_mode[i])
        A_TOR:          hit_vec[i] = (req_word >= dec_lo[i]) && (req_word < dec_hi[i]);
        A_NA4, A_NAPOT: hit_vec[i] = ((req_word & dec_hi[i]) == dec_lo[i]);
        default:        hit_vec[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    hit_found = 1'b0;
    hit_idx   = 4'hF;
    hit_perm  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (hit_vec[i] && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = 4'(i);
        hit_perm  = dec_perm[i];
      end
    end
    case (req_type_i)
      2'b01:   perm_ok = hit_perm[1];
      2'b10:   perm_ok = hit_perm[2];
      default: perm_ok = hit_perm[0];
    endcase
    if (!hit_found)
      chk_fault = !req_priv_m_i;
    else
      chk_fault = (!req_priv_m_i || hit_perm[3]) && !perm_ok;
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state       <= ST_UPD;
      rsp_valid_o <= 1'b0;
      rsp_fault_o <= 1'b0;
      rsp_entry_o <= 4'hF;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg[i]      <= '0;
        addr[i]     <= '0;
        dec_lo[i]   <= '0;
        dec_hi[i]   <= '0;
        dec_mode[i] <= A_OFF;
        dec_perm[i] <= '0;
      end
    end else begin
      if (csr_wr_i && cfg_sel) begin
        for (int i = 0; i < NUM_ENTRIES; i++)
          if (int'(cfg_idx) == i / 4 && !cfg[i][7])
            cfg[i] <= csr_wdata_i[8*(i%4) +: 8] & 8'h9F;
      end
      if (csr_wr_i && addr_sel) begin
        for (int i = 0; i < NUM_ENTRIES; i++)
          if (int'(addr_idx) == i && !addr_lock[i])
            addr[i] <= csr_wdata_i[29:0];
      end

      case (state)
        ST_RDY: if (pmp_wr) state <= ST_UPD;
        ST_UPD: begin
          for (int i = 0; i < NUM_ENTRIES; i++) begin
            dec_lo[i]   <= nxt_lo[i];
            dec_hi[i]   <= nxt_hi[i];
            dec_mode[i] <= cfg[i][4:3];
            dec_perm[i] <= {cfg[i][7], cfg[i][2:0]};
          end
          if (!pmp_wr) state <= ST_RDY;
        end
        default: state <= ST_UPD;
      endcase

      if (accept) begin
        rsp_valid_o <= 1'b1;
        rsp_fault_o <= chk_fault;
        rsp_entry_o <= hit_idx;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule
